// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - single RF write port shared by WB stage and a 2-entry MDU result buffer
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_W,
    output logic [4:0]  rf_W_Reg,
    output logic [31:0] rf_W_data,
    output logic [1:0]  fifo_count
);

    localparam logic [1:0] DEPTH_L  = 2'(DEPTH);
    localparam logic [1:0] STARVE_L = 2'(STARVE_MAX);

    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  starve_q, starve_d;
    logic [4:0]  mem_reg_q  [2];
    logic [4:0]  mem_reg_d  [2];
    logic [31:0] mem_data_q [2];
    logic [31:0] mem_data_d [2];

    logic        w_cand;
    logic        h_cand;
    logic        grant_w;
    logic        grant_h;
    logic        push;
    logic [4:0]  head_reg;
    logic [31:0] head_data;

    // Arbitration, handshakes, RF port drive and next-state for buffer and starvation counter
    always_comb begin
        head_reg  = mem_reg_q[rd_ptr_q];
        head_data = mem_data_q[rd_ptr_q];
        w_cand    = !rst && wb_we && (wb_reg != 5'd0);
        h_cand    = (count_q != 2'd0);
        // The older buffered result wins ties on the same register so RF ends with the younger WB value
        grant_h   = h_cand && (!w_cand || (starve_q == STARVE_L) || (wb_reg == head_reg));
        grant_w   = w_cand && !grant_h;

        mdu_ready = !rst && (count_q < DEPTH_L);
        wb_ready  = !rst && (!wb_we || (wb_reg == 5'd0) || grant_w);
        push      = mdu_valid && mdu_ready && (mdu_reg != 5'd0);

        rf_W      = 1'b0;
        rf_W_Reg  = 5'd0;
        rf_W_data = 32'd0;
        if (grant_h) begin
            rf_W      = 1'b1;
            rf_W_Reg  = head_reg;
            rf_W_data = head_data;
        end else if (grant_w) begin
            rf_W      = 1'b1;
            rf_W_Reg  = wb_reg;
            rf_W_data = wb_data;
        end

        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_reg_d[wr_ptr_q]  = mdu_reg;
            mem_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = !wr_ptr_q;
        end
        if (grant_h) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, grant_h};

        starve_d = starve_q;
        if (grant_h || !h_cand) begin
            starve_d = 2'd0;
        end else if (w_cand && grant_w && (starve_q != STARVE_L)) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // State register; reset discards any buffered results immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            starve_q      <= 2'd0;
            mem_reg_q[0]  <= 5'd0;
            mem_reg_q[1]  <= 5'd0;
            mem_data_q[0] <= 32'd0;
            mem_data_q[1] <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            mem_reg_q  <= mem_reg_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign fifo_count = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_ready;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_reg = 5'd0;
    logic [31:0] mdu_data = 32'd0;
    logic        mdu_ready;
    logic        rf_W;
    logic [4:0]  rf_W_Reg;
    logic [31:0] rf_W_data;
    logic [1:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
        .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_W(rf_W), .rf_W_Reg(rf_W_Reg), .rf_W_data(rf_W_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
    endtask

    task automatic test_reset();
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h1;
        mdu_valid = 1'b1; mdu_reg = 5'd7;
        tick(); #1;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL rst_mdu_ready got %0b exp 0", mdu_ready); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL rst_wb_ready got %0b exp 0", wb_ready); end
        checks++; if (rf_W !== 1'b0 || rf_W_Reg !== 5'd0 || rf_W_data !== 32'd0) begin errors++; $display("FAIL rst_port got %0b/%0d/%0h exp 0/0/0", rf_W, rf_W_Reg, rf_W_data); end
        idle();
        rst = 1'b0;
        tick();
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL post_rst_count got %0d exp 0", fifo_count); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_mdu_ready got %0b exp 1", mdu_ready); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wb_ready got %0b exp 1", wb_ready); end
    endtask

    task automatic test_wb_only();
        wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'h12345678;
        #1;
        checks++; if (rf_W !== 1'b1 || rf_W_Reg !== 5'd5 || rf_W_data !== 32'h12345678) begin errors++; $display("FAIL wb_only_port got %0b/%0d/%0h exp 1/5/12345678", rf_W, rf_W_Reg, rf_W_data); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_only_ready got %0b exp 1", wb_ready); end
        tick(); idle();
    endtask

    task automatic test_mdu_only();
        mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'hCAFEF00D;
        #1;
        checks++; if (mdu_ready !== 1'b1 || rf_W !== 1'b0) begin errors++; $display("FAIL mdu_push_cycle got ready=%0b rf_W=%0b exp 1/0", mdu_ready, rf_W); end
        tick(); idle(); #1;
        checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL mdu_count1 got %0d exp 1", fifo_count); end
        checks++; if (rf_W !== 1'b1 || rf_W_Reg !== 5'd9 || rf_W_data !== 32'hCAFEF00D) begin errors++; $display("FAIL mdu_write got %0b/%0d/%0h exp 1/9/cafef00d", rf_W, rf_W_Reg, rf_W_data); end
        tick();
        checks++; if (fifo_count !== 2'd0 || rf_W !== 1'b0) begin errors++; $display("FAIL mdu_drained got count=%0d rf_W=%0b exp 0/0", fifo_count, rf_W); end
    endtask

    task automatic test_starvation();
        logic [4:0] regs [4];
        regs[0] = 5'd4; regs[1] = 5'd6; regs[2] = 5'd7; regs[3] = 5'd8;
        mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h33;
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            wb_we = 1'b1; wb_reg = regs[i]; wb_data = 32'(100 + i);
            #1;
            checks++; if (rf_W_Reg !== regs[i] || wb_ready !== 1'b1) begin errors++; $display("FAIL starve_wb%0d got reg=%0d ready=%0b exp %0d/1", i, rf_W_Reg, wb_ready, regs[i]); end
            tick();
        end
        wb_we = 1'b1; wb_reg = regs[3]; wb_data = 32'h88;
        #1;
        checks++; if (rf_W_Reg !== 5'd3 || rf_W_data !== 32'h33 || wb_ready !== 1'b0) begin errors++; $display("FAIL starve_forced got reg=%0d data=%0h ready=%0b exp 3/33/0", rf_W_Reg, rf_W_data, wb_ready); end
        tick();
        checks++; if (rf_W_Reg !== 5'd8 || rf_W_data !== 32'h88 || wb_ready !== 1'b1 || fifo_count !== 2'd0) begin errors++; $display("FAIL starve_after got reg=%0d data=%0h ready=%0b cnt=%0d exp 8/88/1/0", rf_W_Reg, rf_W_data, wb_ready, fifo_count); end
        tick(); idle();
    endtask

    task automatic test_conflict();
        mdu_valid = 1'b1; mdu_reg = 5'd10; mdu_data = 32'hAAAA0000;
        tick(); idle();
        wb_we = 1'b1; wb_reg = 5'd10; wb_data = 32'hBBBB1111;
        #1;
        checks++; if (rf_W_Reg !== 5'd10 || rf_W_data !== 32'hAAAA0000 || wb_ready !== 1'b0) begin errors++; $display("FAIL conflict_head got %0d/%0h ready=%0b exp 10/aaaa0000/0", rf_W_Reg, rf_W_data, wb_ready); end
        tick();
        checks++; if (rf_W_data !== 32'hBBBB1111 || wb_ready !== 1'b1) begin errors++; $display("FAIL conflict_wb got %0h ready=%0b exp bbbb1111/1", rf_W_data, wb_ready); end
        tick(); idle();
    endtask

    task automatic test_full();
        wb_we = 1'b1; wb_reg = 5'd20; wb_data = 32'h20;
        mdu_valid = 1'b1; mdu_reg = 5'd11; mdu_data = 32'h11;
        tick();
        mdu_reg = 5'd12; mdu_data = 32'h12;
        #1;
        checks++; if (mdu_ready !== 1'b1 || rf_W_Reg !== 5'd20) begin errors++; $display("FAIL full_second_push got ready=%0b reg=%0d exp 1/20", mdu_ready, rf_W_Reg); end
        tick();
        mdu_reg = 5'd13; mdu_data = 32'h13;
        #1;
        checks++; if (fifo_count !== 2'd2 || mdu_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt=%0d ready=%0b exp 2/0", fifo_count, mdu_ready); end
        tick();
        wb_we = 1'b0;
        #1;
        checks++; if (mdu_ready !== 1'b0 || rf_W_Reg !== 5'd11 || fifo_count !== 2'd2) begin errors++; $display("FAIL full_pop got ready=%0b reg=%0d cnt=%0d exp 0/11/2", mdu_ready, rf_W_Reg, fifo_count); end
        tick();
        checks++; if (mdu_ready !== 1'b1 || rf_W_Reg !== 5'd12 || fifo_count !== 2'd1) begin errors++; $display("FAIL full_accept got ready=%0b reg=%0d cnt=%0d exp 1/12/1", mdu_ready, rf_W_Reg, fifo_count); end
        tick(); idle(); #1;
        checks++; if (rf_W_Reg !== 5'd13 || rf_W_data !== 32'h13 || fifo_count !== 2'd1) begin errors++; $display("FAIL full_third got reg=%0d data=%0h cnt=%0d exp 13/13/1", rf_W_Reg, rf_W_data, fifo_count); end
        tick();
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        mdu_valid = 1'b1; mdu_reg = 5'd14; mdu_data = 32'h14;
        tick();
        mdu_reg = 5'd15; mdu_data = 32'h15;
        #1;
        checks++; if (rf_W_Reg !== 5'd14 || fifo_count !== 2'd1) begin errors++; $display("FAIL b2b_first got reg=%0d cnt=%0d exp 14/1", rf_W_Reg, fifo_count); end
        tick(); idle(); #1;
        checks++; if (rf_W_Reg !== 5'd15 || rf_W_data !== 32'h15 || fifo_count !== 2'd1) begin errors++; $display("FAIL b2b_second got reg=%0d data=%0h cnt=%0d exp 15/15/1", rf_W_Reg, rf_W_data, fifo_count); end
        tick();
    endtask

    task automatic test_zero_reg();
        mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'hDEAD;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL zero_mdu_ready got %0b exp 1", mdu_ready); end
        tick(); idle(); #1;
        checks++; if (fifo_count !== 2'd0 || rf_W !== 1'b0) begin errors++; $display("FAIL zero_mdu_drop got cnt=%0d rf_W=%0b exp 0/0", fifo_count, rf_W); end
        wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hBEEF;
        #1;
        checks++; if (wb_ready !== 1'b1 || rf_W !== 1'b0) begin errors++; $display("FAIL zero_wb got ready=%0b rf_W=%0b exp 1/0", wb_ready, rf_W); end
        tick(); idle();
    endtask

    task automatic test_reset_mid();
        wb_we = 1'b1; wb_reg = 5'd21; wb_data = 32'h21;
        mdu_valid = 1'b1; mdu_reg = 5'd16; mdu_data = 32'h16;
        tick();
        mdu_reg = 5'd17; mdu_data = 32'h17;
        tick();
        mdu_valid = 1'b0;
        #2;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL rmid_pre got %0d exp 2", fifo_count); end
        rst = 1'b1;
        #1;
        checks++; if (fifo_count !== 2'd0 || rf_W !== 1'b0 || mdu_ready !== 1'b0 || wb_ready !== 1'b0) begin errors++; $display("FAIL rmid_assert got cnt=%0d rf_W=%0b mr=%0b wr=%0b exp 0/0/0/0", fifo_count, rf_W, mdu_ready, wb_ready); end
        tick(); idle();
        rst = 1'b0;
        tick();
        checks++; if (rf_W !== 1'b0 || fifo_count !== 2'd0 || mdu_ready !== 1'b1) begin errors++; $display("FAIL rmid_release got rf_W=%0b cnt=%0d mr=%0b exp 0/0/1", rf_W, fifo_count, mdu_ready); end
        tick();
        checks++; if (rf_W !== 1'b0) begin errors++; $display("FAIL rmid_stale got rf_W=%0b exp 0", rf_W); end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_mdu_only();
        test_starvation();
        test_conflict();
        test_full();
        test_back_to_back();
        test_zero_reg();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
